frame_read_sched: RTL and testbench

//  Sequences readout of the per-channel capture buffers after a slot cycle completes.

---
 rtl/frame_read_sched.sv | 181 ++++++++++++++++++
 tb/tb_frame_read_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_read_sched.sv
// frame_read_sched: walks every vchn/chan buffer segment after a capture
// completes, reading each buffer through a shared address and emitting a
// header word plus the buffer words on a valid/ready stream.
`timescale 1ns/1ps
module frame_read_sched #(
  parameter int         NCHAN   = 4,
  parameter int         NVCHN   = 4,
  parameter int         ADDR_W  = 8,
  parameter int         DATA_W  = 32,
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_complite,
  input  logic [NCHAN*ADDR_W-1:0] i_data_len,
  input  logic [NCHAN*DATA_W-1:0] i_rd_data,
  output logic [1:0]              o_rd_vchn,
  output logic [1:0]              o_rd_chan,
  output logic [ADDR_W-1:0]       o_rd_addr,
  output logic [DATA_W-1:0]       o_out_data,
  output logic                    o_out_vld,
  input  logic                    i_out_rdy,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_overrun
);

  localparam int PAD_W = DATA_W - 12 - ADDR_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  logic [2:0]        state;
  logic [1:0]        vchn;
  logic [1:0]        chan;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] seg_len;
  logic              frame_done_r;
  logic              overrun_r;

  logic [ADDR_W-1:0] cur_len_p0;
  logic [DATA_W-1:0] hdr_word_p0;
  logic [2:0]        occ_p0;
  logic              credit_p0;
  logic              hdr_issue_p0;
  logic              rd_issue_p0;

  logic              vld_p1;
  logic              hdr_p1;
  logic [DATA_W-1:0] hdr_data_p1;
  logic [DATA_W-1:0] push_data_p1;

  logic [DATA_W-1:0] fifo_mem [2];
  logic [1:0]        fifo_cnt;
  logic              fifo_wp;
  logic              fifo_rp;
  logic              pop;
  logic              drain_ok;

  // Issue stage: occupancy counts the word leaving the FIFO this cycle so a
  // full pipeline still sustains one word per clock without overflowing.
  assign pop          = (fifo_cnt != 2'd0) && i_out_rdy;
  assign occ_p0       = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, vld_p1};
  assign credit_p0    = (occ_p0 < 3'd2);
  assign cur_len_p0   = i_data_len[int'(chan)*ADDR_W +: ADDR_W];
  assign hdr_word_p0  = {HDR_TAG, vchn, chan, {PAD_W{1'b0}}, cur_len_p0};
  assign hdr_issue_p0 = (state == ST_HDR) && credit_p0;
  assign rd_issue_p0  = (state == ST_DATA) && credit_p0;

  // Landing stage: RAM data (chan still stable) or the registered header.
  assign push_data_p1 = hdr_p1 ? hdr_data_p1 : i_rd_data[int'(chan)*DATA_W +: DATA_W];
  assign drain_ok     = !vld_p1 && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop));

  // Segment sequencer: header, addresses, advance chan/vchn, then drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      vchn         <= 2'd0;
      chan         <= 2'd0;
      rd_addr      <= '0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      overrun_r    <= i_complite && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (i_complite) begin
            state <= ST_HDR;
            vchn  <= 2'd0;
            chan  <= 2'd0;
          end
        end
        ST_HDR: begin
          if (credit_p0) begin
            if (cur_len_p0 != '0) begin
              state   <= ST_DATA;
              rd_addr <= '0;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_DATA: begin
          if (credit_p0) begin
            if (rd_addr == seg_len - ADDR_W'(1)) state <= ST_NEXT;
            else                                  rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        ST_NEXT: begin
          if (chan == 2'(NCHAN - 1)) begin
            chan <= 2'd0;
            if (vchn == 2'(NVCHN - 1)) begin
              vchn  <= 2'd0;
              state <= ST_DRAIN;
            end else begin
              vchn  <= vchn + 2'd1;
              state <= ST_HDR;
            end
          end else begin
            chan  <= chan + 2'd1;
            state <= ST_HDR;
          end
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            state        <= ST_IDLE;
            frame_done_r <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In-flight tracking: one slot for a header or a pending RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      hdr_p1 <= 1'b0;
    end else begin
      vld_p1 <= hdr_issue_p0 || rd_issue_p0;
      hdr_p1 <= hdr_issue_p0;
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
    end else begin
      fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
      if (vld_p1) fifo_wp <= ~fifo_wp;
      if (pop)    fifo_rp <= ~fifo_rp;
    end
  end

  // Datapath registers: segment length, header word and FIFO storage.
  always_ff @(posedge clk) begin
    if (hdr_issue_p0) begin
      seg_len     <= cur_len_p0;
      hdr_data_p1 <= hdr_word_p0;
    end
    if (vld_p1) fifo_mem[fifo_wp] <= push_data_p1;
  end

  assign o_rd_vchn    = vchn;
  assign o_rd_chan    = chan;
  assign o_rd_addr    = rd_addr;
  assign o_out_vld    = (fifo_cnt != 2'd0);
  assign o_out_data   = o_out_vld ? fifo_mem[fifo_rp] : '0;
  assign o_busy       = (state != ST_IDLE);
  assign o_frame_done = frame_done_r;
  assign o_overrun    = overrun_r;

endmodule

// File: tb/tb_frame_read_sched.sv
// tb_frame_read_sched: randomized frames against a queue-based model of the
// frame word sequence; also checks stall stability, pulses and reset.
`timescale 1ns/1ps
module tb_frame_read_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_complite = 1'b0;
  logic [31:0]  i_data_len;
  logic [127:0] i_rd_data = '0;
  logic [1:0]   o_rd_vchn;
  logic [1:0]   o_rd_chan;
  logic [7:0]   o_rd_addr;
  logic [31:0]  o_out_data;
  logic         o_out_vld;
  logic         i_out_rdy = 1'b1;
  logic         o_busy;
  logic         o_frame_done;
  logic         o_overrun;

  frame_read_sched dut (
    .clk          (clk),
    .rst          (rst),
    .i_complite   (i_complite),
    .i_data_len   (i_data_len),
    .i_rd_data    (i_rd_data),
    .o_rd_vchn    (o_rd_vchn),
    .o_rd_chan    (o_rd_chan),
    .o_rd_addr    (o_rd_addr),
    .o_out_data   (o_out_data),
    .o_out_vld    (o_out_vld),
    .i_out_rdy    (i_out_rdy),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  len_tab [4][4];
  logic [15:0] salt = 16'h0;
  int          rdy_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          cyc = 0;
  int          last_xfer_cyc = 0;
  int          fd_cnt = 0;
  int          ov_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] buf_word(input int v, input int c, input int a);
    return {salt, 4'(v), 4'(c), 8'(a)};
  endfunction

  // Capture buffers: one-cycle read latency, every channel answers.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++)
      i_rd_data[c*32 +: 32] <= buf_word(int'(o_rd_vchn), c, int'(o_rd_addr));
  end

  // Length table presented for whichever vchn the DUT is reading.
  always_comb begin
    i_data_len = '0;
    for (int c = 0; c < 4; c++) i_data_len[c*8 +: 8] = len_tab[o_rd_vchn][c];
  end

  // Drives ready, records transfers, checks stall stability and pulses.
  always @(negedge clk) begin
    cyc++;
    i_out_rdy = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld", 32'(o_out_vld), 32'd1);
        chk("stall_data", o_out_data, prev_data);
      end
      prev_stall = o_out_vld && !i_out_rdy;
      prev_data  = o_out_data;
      if (o_out_vld && i_out_rdy) begin
        got_q.push_back(o_out_data);
        last_xfer_cyc = cyc;
      end
      if (o_frame_done) begin
        fd_cnt++;
        chk("done_lat", 32'(cyc - last_xfer_cyc), 32'd1);
      end
      if (o_overrun) ov_cnt++;
    end
  end

  function automatic void build_exp(input int nfr);
    exp_q.delete();
    for (int f = 0; f < nfr; f++)
      for (int v = 0; v < 4; v++)
        for (int c = 0; c < 4; c++) begin
          exp_q.push_back({8'hA5, 2'(v), 2'(c), 12'h000, len_tab[v][c]});
          for (int a = 0; a < int'(len_tab[v][c]); a++) exp_q.push_back(buf_word(v, c, a));
        end
  endfunction

  function automatic void rand_lens();
    for (int v = 0; v < 4; v++)
      for (int c = 0; c < 4; c++) begin
        int r;
        r = $urandom_range(0, 15);
        len_tab[v][c] = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(1, 20));
      end
  endfunction

  task automatic run_frame(input string name, input int mode, input int nfr, input int ov_at);
    int guard;
    int done_seen;
    int busy_bad;
    rdy_mode  = mode;
    build_exp(nfr);
    got_q.delete();
    fd_cnt    = 0;
    ov_cnt    = 0;
    busy_bad  = 0;
    done_seen = 0;
    guard     = 0;
    @(negedge clk); i_complite = 1'b1;
    @(negedge clk); i_complite = 1'b0;
    chk({name, "_lat1"}, 32'(o_out_vld), 32'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 32'(o_out_vld), 32'd0);
    @(negedge clk);
    chk({name, "_lat3"}, 32'(o_out_vld), 32'd1);
    chk({name, "_hdr0"}, o_out_data, exp_q[0]);
    while (done_seen < nfr && guard < 30000) begin
      @(negedge clk);
      guard++;
      i_complite = 1'b0;
      if (guard == ov_at) i_complite = 1'b1;
      if (o_frame_done) begin
        done_seen++;
        if (done_seen < nfr) i_complite = 1'b1;
      end else if (!o_busy) begin
        busy_bad++;
      end
    end
    i_complite = 1'b0;
    chk({name, "_frames"}, 32'(done_seen), 32'(nfr));
    repeat (6) @(negedge clk);
    chk({name, "_fd_cnt"}, 32'(fd_cnt), 32'(nfr));
    chk({name, "_ov_cnt"}, 32'(ov_cnt), (ov_at > 0) ? 32'd1 : 32'd0);
    chk({name, "_busy_gap"}, 32'(busy_bad), 32'd0);
    chk({name, "_idle"}, 32'(o_busy), 32'd0);
    chk({name, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int n_at;
    int g;
    for (int v = 0; v < 4; v++) for (int c = 0; c < 4; c++) len_tab[v][c] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_vld",   32'(o_out_vld), 32'd0);
    chk("rst_data",  o_out_data, 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_addr",  32'(o_rd_addr), 32'd0);
    chk("rst_chan",  32'(o_rd_chan), 32'd0);
    chk("rst_vchn",  32'(o_rd_vchn), 32'd0);
    chk("rst_done",  32'(o_frame_done), 32'd0);
    chk("rst_ovr",   32'(o_overrun), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // All lengths zero: headers only.
    run_frame("zero", 0, 1, 0);

    // All lengths 3 with plain {vchn,chan,addr} words, free-running then stalled.
    salt = 16'h0;
    for (int v = 0; v < 4; v++) for (int c = 0; c < 4; c++) len_tab[v][c] = 8'd3;
    run_frame("len3", 0, 1, 0);
    run_frame("len3_stall", 1, 1, 0);

    // Maximum length on channel 2 only.
    salt = 16'h5A5A;
    for (int v = 0; v < 4; v++) for (int c = 0; c < 4; c++) len_tab[v][c] = (c == 2) ? 8'd255 : 8'd0;
    run_frame("max255", 0, 1, 0);

    // Second completion while busy.
    salt = 16'($urandom);
    rand_lens();
    run_frame("overrun", 1, 1, 50);

    // Back-to-back frames: completion lands in the frame-done cycle.
    salt = 16'($urandom);
    rand_lens();
    run_frame("b2b", 0, 2, 0);

    // Reset in the middle of a frame.
    salt = 16'($urandom);
    for (int v = 0; v < 4; v++) for (int c = 0; c < 4; c++) len_tab[v][c] = 8'd20;
    rdy_mode = 1;
    got_q.delete();
    @(negedge clk); i_complite = 1'b1;
    @(negedge clk); i_complite = 1'b0;
    g = 0;
    while (got_q.size() < 10 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("mid_pre_words", 32'(got_q.size() >= 10), 32'd1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_at = got_q.size();
    chk("mid_rst_vld",  32'(o_out_vld), 32'd0);
    chk("mid_rst_data", o_out_data, 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_addr", 32'(o_rd_addr), 32'd0);
    chk("mid_rst_chan", 32'(o_rd_chan), 32'd0);
    chk("mid_rst_vchn", 32'(o_rd_vchn), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_quiet_words", 32'(got_q.size()), 32'(n_at));
    chk("mid_quiet_busy", 32'(o_busy), 32'd0);
    salt = 16'($urandom);
    rand_lens();
    run_frame("after_rst", 1, 1, 0);

    // Extra random frames.
    for (int k = 0; k < 2; k++) begin
      salt = 16'($urandom);
      rand_lens();
      run_frame($sformatf("rnd%0d", k), k & 1, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no completion, expected finish before %0d ns", 900000);
    $fatal(1);
  end

endmodule
